// File: rtl/imc22_pkg.sv
// imc22_pkg: shared constants for the IMC-22 scratchpad SRAM and its arbiter.
`default_nettype none

package imc22_pkg;

  localparam int IMC22_SRAM_BYTES = 1024;
  localparam int IMC22_LINE_BYTES = 16;

  localparam int IMC22_PORT_CPU = 0;
  localparam int IMC22_PORT_NPU = 1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ARB_KIND_RR    = 1'b0,
    ARB_KIND_FIXED = 1'b1
  } arb_kind_e;

endpackage : imc22_pkg

`default_nettype wire

// File: rtl/imc22_rr_arbiter.sv
// imc22_rr_arbiter: combinational one-hot grant (round-robin or fixed priority) plus the rotating pointer.
`default_nettype none

module imc22_rr_arbiter
  import imc22_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = ARB_RR,
  localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_any
);

  localparam arb_kind_e KIND = (ARB_MODE == ARB_FIXED) ? ARB_KIND_FIXED : ARB_KIND_RR;
  localparam logic [IDX_W:0]   NUM_P  = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(NUM_PORTS - 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   scan;

  // Fixed priority is just round-robin with the search always starting at port 0.
  assign base = (KIND == ARB_KIND_FIXED) ? '0 : rr_ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = {1'b0, base} + (IDX_W+1)'(k);
      if (scan >= NUM_P) begin
        scan = scan - NUM_P;
      end
      if (!grant_any && req_valid[scan[IDX_W-1:0]]) begin
        grant_any                  = 1'b1;
        grant_idx                  = scan[IDX_W-1:0];
        grant[scan[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == LAST_P) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule : imc22_rr_arbiter

`default_nettype wire

// File: rtl/imc22_sram_arb.sv
// imc22_sram_arb: multi-port byte-addressed scratchpad with line reads, byte-enabled line writes
// and wrap-around addressing at the top of the array.
`default_nettype none

module imc22_sram_arb
  import imc22_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int DEPTH_BYTES = IMC22_SRAM_BYTES,
  parameter int LINE_BYTES  = IMC22_LINE_BYTES,
  parameter int ARB_MODE    = ARB_RR,
  localparam int ADDR_W     = $clog2(DEPTH_BYTES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
  input  logic [NUM_PORTS*LINE_BYTES*8-1:0] req_wdata,
  input  logic [NUM_PORTS*LINE_BYTES-1:0]   req_be,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [LINE_BYTES*8-1:0]           rsp_rdata,
  output logic                              busy
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]    grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_any;

  logic [ADDR_W-1:0]       sel_addr;
  logic                    sel_we;
  logic [LINE_BYTES*8-1:0] sel_wdata;
  logic [LINE_BYTES-1:0]   sel_be;

  logic [7:0]              mem [DEPTH_BYTES];
  logic [ADDR_W-1:0]       byte_addr [LINE_BYTES];
  logic [LINE_BYTES*8-1:0] rd_line;

  imc22_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign busy      = grant_any;

  // Grant is one-hot, so an AND-OR mux picks the winning port's payload.
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
        sel_we    = req_we[p];
        sel_wdata = req_wdata[p*LINE_BYTES*8 +: LINE_BYTES*8];
        sel_be    = req_be[p*LINE_BYTES +: LINE_BYTES];
      end
    end
  end

  // Byte lanes take the natural ADDR_W-bit overflow, which is exactly the wrap at DEPTH_BYTES.
  for (genvar i = 0; i < LINE_BYTES; i++) begin : g_lane
    assign byte_addr[i]       = sel_addr + ADDR_W'(i);
    assign rd_line[i*8 +: 8]  = mem[byte_addr[i]];
  end

  // Array contents are deliberately left without a reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (grant_any && sel_we && sel_be[i]) begin
        mem[byte_addr[i]] <= sel_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (grant_any && !sel_we) ? grant : '0;
      if (grant_any && !sel_we) begin
        rsp_rdata <= rd_line;
      end
    end
  end

endmodule : imc22_sram_arb

`default_nettype wire

// File: tb/tb_imc22_sram_arb.sv
// tb_imc22_sram_arb: directed vector table plus hand sequences for reset, round-robin and fixed priority.
`default_nettype none

module tb_imc22_sram_arb;

  localparam int NP = 2;
  localparam int AW = 10;
  localparam int LB = 16;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_we;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*LB*8-1:0] req_wdata;
  logic [NP*LB-1:0]  req_be;

  logic [NP-1:0]     ready_rr, ready_fp;
  logic [NP-1:0]     rsp_valid_rr, rsp_valid_fp;
  logic [LB*8-1:0]   rdata_rr, rdata_fp;
  logic              busy_rr, busy_fp;

  imc22_sram_arb #(.NUM_PORTS(NP), .DEPTH_BYTES(1024), .LINE_BYTES(LB), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_rr), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_rr), .rsp_rdata(rdata_rr), .busy(busy_rr)
  );

  imc22_sram_arb #(.NUM_PORTS(NP), .DEPTH_BYTES(1024), .LINE_BYTES(LB), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_fp), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_fp), .rsp_rdata(rdata_fp), .busy(busy_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic         we;
    logic [9:0]   addr;
    logic [127:0] wdata;
    logic [15:0]  be;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [9:0] addr,
                          input logic [127:0] wdata, input logic [15:0] be);
    req_valid[p]              = 1'b1;
    req_we[p]                 = we;
    req_addr[p*AW +: AW]      = addr;
    req_wdata[p*LB*8 +: LB*8] = wdata;
    req_be[p*LB +: LB]        = be;
  endtask

  initial begin
    logic [NP-1:0] onehot;
    logic [NP-1:0] exp_g;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_req();

    vecs[0] = '{1, 1'b1, 10'h010, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 128'h0};
    vecs[1] = '{1, 1'b0, 10'h010, 128'h0, 16'h0, 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[2] = '{1, 1'b1, 10'h000, 128'h0, 16'hFFFF, 128'h0};
    vecs[3] = '{0, 1'b1, 10'h3F8, {16{8'hA5}}, 16'hFFFF, 128'h0};
    vecs[4] = '{0, 1'b0, 10'h3F8, 128'h0, 16'h0, {16{8'hA5}}};
    vecs[5] = '{1, 1'b0, 10'h000, 128'h0, 16'h0, {64'h0, {8{8'hA5}}}};
    vecs[6] = '{0, 1'b1, 10'h020, 128'h0, 16'hFFFF, 128'h0};
    vecs[7] = '{1, 1'b1, 10'h020, {16{8'hFF}}, 16'h0005, 128'h0};
    vecs[8] = '{1, 1'b0, 10'h020, 128'h0, 16'h0, 128'h000000000000000000000000_00FF00FF};
    vecs[9] = '{0, 1'b0, 10'h011, 128'h0, 16'h0, 128'hFF0F0E0D0C0B0A090807060504030201};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rsp_valid", 128'(rsp_valid_rr), 128'h0);
    check("reset_rdata", rdata_rr, 128'h0);
    check("reset_ready", 128'(ready_rr), 128'h0);
    check("reset_busy", 128'(busy_rr), 128'h0);

    // Vectors run back-to-back: each one is accepted on the edge right after the previous.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      clear_req();
      set_port(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be);
      onehot = '0;
      onehot[vecs[v].port] = 1'b1;
      #1;
      check($sformatf("v%0d_ready", v), 128'(ready_rr), 128'(onehot));
      check($sformatf("v%0d_busy", v), 128'(busy_rr), 128'h1);
      @(posedge clk);
      #1;
      if (vecs[v].we) begin
        check($sformatf("v%0d_no_rsp", v), 128'(rsp_valid_rr), 128'h0);
      end else begin
        check($sformatf("v%0d_rsp_valid", v), 128'(rsp_valid_rr), 128'(onehot));
        check($sformatf("v%0d_rdata", v), rdata_rr, vecs[v].exp);
      end
    end
    @(negedge clk);
    clear_req();
    #1;
    check("idle_ready", 128'(ready_rr), 128'h0);
    @(posedge clk);
    #1;
    check("rsp_one_cycle", 128'(rsp_valid_rr), 128'h0);
    check("rdata_held", rdata_rr, 128'hFF0F0E0D0C0B0A090807060504030201);

    // Reset right after a read is accepted must swallow its response and pointer advance.
    @(negedge clk);
    set_port(0, 1'b0, 10'h010, 128'h0, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_rsp_valid", 128'(rsp_valid_rr), 128'h0);
    check("rstmid_rdata", rdata_rr, 128'h0);
    clear_req();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_rsp_after", 128'(rsp_valid_rr), 128'h0);

    // Both ports valid for six cycles.
    @(negedge clk);
    set_port(0, 1'b0, 10'h010, 128'h0, 16'h0);
    set_port(1, 1'b0, 10'h3F8, 128'h0, 16'h0);
    for (int c = 0; c < 6; c++) begin
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("rr_c%0d_ready", c), 128'(ready_rr), 128'(exp_g));
      check($sformatf("fp_c%0d_ready", c), 128'(ready_fp), 128'h1);
      @(posedge clk);
      #1;
      check($sformatf("rr_c%0d_rsp", c), 128'(rsp_valid_rr), 128'(exp_g));
      check($sformatf("rr_c%0d_rdata", c), rdata_rr,
            (c % 2 == 0) ? 128'h0F0E0D0C0B0A09080706050403020100 : {16{8'hA5}});
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    #1;
    check("fp_port1_ready", 128'(ready_fp), 128'h2);
    @(posedge clk);
    #1;
    check("fp_port1_rsp", 128'(rsp_valid_fp), 128'h2);
    check("fp_port1_rdata", rdata_fp, {16{8'hA5}});
    @(negedge clk);
    clear_req();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_imc22_sram_arb

`default_nettype wire
